ipv4_checksum_verify: RTL and testbench

// Verifies the header checksum of a complete 20-byte IPv4 header (IHL=5) presented in a single AXI-Stream beat.

---
 rtl/ipv4_checksum_verify.sv | 119 +++++++++++
 tb/tb_ipv4_checksum_verify.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/ipv4_checksum_verify.sv
// ipv4_checksum_verify
// Checks the header checksum of a 20-byte IPv4 header carried in one
// AXI-Stream beat. The ten 16-bit header words, checksum field included, are
// summed in one's-complement arithmetic over three pipeline stages. The
// header is good when the folded sum is 16'hFFFF. One result beat is emitted
// per header beat, in order, with the pass bit in tdata[0].
// Neither side can stall: the input is always ready and the downstream
// tready is ignored.

module ipv4_checksum_verify #(
    parameter int IN_BYTES  = 20,   // header stream width in bytes, >= 20
    parameter int OUT_BYTES = 1,    // result stream width in bytes, >= 1
    parameter int USER_W    = 1     // tuser width on both streams
) (
    input  logic                     clk,
    input  logic                     areset,

    // Header stream (slave side)
    input  logic [8*IN_BYTES-1:0]    ipv4_header_tdata_i,
    input  logic                     ipv4_header_tvalid_i,
    output logic                     ipv4_header_tready_o,
    input  logic [IN_BYTES-1:0]      ipv4_header_tkeep_i,
    input  logic                     ipv4_header_tlast_i,
    input  logic [USER_W-1:0]        ipv4_header_tuser_i,

    // Result stream (master side)
    output logic [8*OUT_BYTES-1:0]   ipv4_checksum_valid_tdata_o,
    output logic                     ipv4_checksum_valid_tvalid_o,
    input  logic                     ipv4_checksum_valid_tready_i,
    output logic [OUT_BYTES-1:0]     ipv4_checksum_valid_tkeep_o,
    output logic                     ipv4_checksum_valid_tlast_o,
    output logic [USER_W-1:0]        ipv4_checksum_valid_tuser_o
);

    // Stage 1: five 17-bit pair sums
    logic              s1_valid_q, s1_valid_d;
    logic [4:0][16:0]  s1_sum_q,   s1_sum_d;

    // Stage 2: 20-bit total of the pair sums (5 * 0x1FFFE fits in 20 bits)
    logic              s2_valid_q, s2_valid_d;
    logic [19:0]       s2_sum_q,   s2_sum_d;

    // Stage 3: folded result reduced to the pass bit
    logic              s3_valid_q, s3_valid_d;
    logic              s3_pass_q,  s3_pass_d;

    // Fold intermediates
    logic [16:0]       fold1;
    logic [15:0]       fold2;

    // Header sits in the low 160 bits; everything above, plus the sideband
    // signals and the downstream ready, has no effect on the result.
    logic unused_inputs;
    assign unused_inputs = ^{ipv4_header_tdata_i, ipv4_header_tkeep_i,
                             ipv4_header_tlast_i, ipv4_header_tuser_i,
                             ipv4_checksum_valid_tready_i};

    // Stage 1 next state: split the header into ten words and add adjacent pairs.
    always_comb begin
        // NOTE: every signal written here gets a value on every path, so no latch is inferred.
        s1_valid_d = ipv4_header_tvalid_i;
        s1_sum_d   = '0;
        for (int i = 0; i < 5; i++) begin
            s1_sum_d[i] = {1'b0, ipv4_header_tdata_i[159 - 32*i -: 16]}
                        + {1'b0, ipv4_header_tdata_i[143 - 32*i -: 16]};
        end
    end

    // Stage 2 next state: add the five pair sums into one 20-bit total.
    always_comb begin
        s2_valid_d = s1_valid_q;
        s2_sum_d   = '0;
        for (int i = 0; i < 5; i++) begin
            s2_sum_d = s2_sum_d + {3'b000, s1_sum_q[i]};
        end
    end

    // Stage 3 next state: two end-around-carry folds, then compare to all ones.
    always_comb begin
        s3_valid_d = s2_valid_q;
        fold1      = {1'b0, s2_sum_q[15:0]} + {13'd0, s2_sum_q[19:16]};
        fold2      = fold1[15:0] + {15'd0, fold1[16]};
        s3_pass_d  = (fold2 == 16'hFFFF);
    end

    // Valid flags: the only state cleared by reset, so in-flight beats are dropped.
    always_ff @(posedge clk or posedge areset) begin
        // NOTE: sequential state uses non-blocking assignments so all stages update together.
        if (areset) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s3_valid_q <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            s3_valid_q <= s3_valid_d;
        end
    end

    // Datapath registers: free-running, qualified downstream by the valid flags.
    always_ff @(posedge clk) begin
        // NOTE: data registers are deliberately not reset; their contents are ignored while invalid.
        s1_sum_q  <= s1_sum_d;
        s2_sum_q  <= s2_sum_d;
        s3_pass_q <= s3_pass_d;
    end

    // Output beat: pass bit in tdata[0], masked to 0 while no result is valid.
    always_comb begin
        ipv4_header_tready_o            = 1'b1;
        ipv4_checksum_valid_tdata_o     = '0;
        ipv4_checksum_valid_tdata_o[0]  = s3_valid_q & s3_pass_q;
        ipv4_checksum_valid_tvalid_o    = s3_valid_q;
        ipv4_checksum_valid_tkeep_o     = '1;
        ipv4_checksum_valid_tlast_o     = 1'b1;
        ipv4_checksum_valid_tuser_o     = '0;
    end

endmodule

// File: tb/tb_ipv4_checksum_verify.sv
// Self-checking bench for ipv4_checksum_verify. Each driven header pushes its
// expected pass bit and due cycle into a scoreboard; a negedge monitor pops
// and compares every result beat, and flags missing or unexpected beats.

module tb_ipv4_checksum_verify;

    localparam int IN_BYTES  = 20;
    localparam int OUT_BYTES = 1;
    localparam int USER_W    = 1;
    localparam int LATENCY   = 3;

    typedef struct {
        logic pass;
        int   due;
    } exp_t;

    logic                    clk = 1'b0;
    logic                    areset;
    logic [8*IN_BYTES-1:0]   hdr_tdata;
    logic                    hdr_tvalid;
    logic                    hdr_tready;
    logic [IN_BYTES-1:0]     hdr_tkeep;
    logic                    hdr_tlast;
    logic [USER_W-1:0]       hdr_tuser;
    logic [8*OUT_BYTES-1:0]  res_tdata;
    logic                    res_tvalid;
    logic                    res_tready;
    logic [OUT_BYTES-1:0]    res_tkeep;
    logic                    res_tlast;
    logic [USER_W-1:0]       res_tuser;

    int   vectors     = 0;
    int   miscompares = 0;
    int   cyc         = 0;
    exp_t sb[$];

    ipv4_checksum_verify #(
        .IN_BYTES (IN_BYTES),
        .OUT_BYTES(OUT_BYTES),
        .USER_W   (USER_W)
    ) dut (
        .clk                          (clk),
        .areset                       (areset),
        .ipv4_header_tdata_i          (hdr_tdata),
        .ipv4_header_tvalid_i         (hdr_tvalid),
        .ipv4_header_tready_o         (hdr_tready),
        .ipv4_header_tkeep_i          (hdr_tkeep),
        .ipv4_header_tlast_i          (hdr_tlast),
        .ipv4_header_tuser_i          (hdr_tuser),
        .ipv4_checksum_valid_tdata_o  (res_tdata),
        .ipv4_checksum_valid_tvalid_o (res_tvalid),
        .ipv4_checksum_valid_tready_i (res_tready),
        .ipv4_checksum_valid_tkeep_o  (res_tkeep),
        .ipv4_checksum_valid_tlast_o  (res_tlast),
        .ipv4_checksum_valid_tuser_o  (res_tuser)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, observed, expected, cyc);
        end
    endtask

    // One's-complement sum of the ten words, or of nine with the checksum word left out.
    function automatic logic [15:0] ones_sum(input logic [159:0] h, input bit skip_cs);
        logic [31:0] acc;
        acc = 32'd0;
        for (int i = 0; i < 10; i++) begin
            if (!(skip_cs && i == 5)) acc = acc + 32'(h[159 - 16*i -: 16]);
        end
        while (acc[31:16] != 16'd0) acc = {16'd0, acc[15:0]} + {16'd0, acc[31:16]};
        return acc[15:0];
    endfunction

    function automatic logic [159:0] with_cs(input logic [159:0] h, input logic [15:0] cs);
        logic [159:0] r;
        r = h;
        r[79:64] = cs;
        return r;
    endfunction

    function automatic logic [159:0] rand_hdr();
        logic [159:0] r;
        for (int i = 0; i < 5; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [159:0] good_hdr(input logic [159:0] h);
        return with_cs(h, ~ones_sum(h, 1'b1));
    endfunction

    function automatic logic [159:0] bad_hdr(input logic [159:0] h);
        logic [15:0] good, delta;
        good  = ~ones_sum(h, 1'b1);
        delta = 16'($urandom_range(1, 16'hFFFF));
        return with_cs(h, good ^ delta);
    endfunction

    // Drive one header in the cycle after the current edge; it is captured on the next edge.
    task automatic beat(input logic [159:0] h);
        exp_t e;
        @(posedge clk);
        #1;
        hdr_tdata  = h;
        hdr_tvalid = 1'b1;
        hdr_tkeep  = IN_BYTES'($urandom);
        hdr_tlast  = 1'($urandom);
        hdr_tuser  = USER_W'($urandom);
        e.pass = (ones_sum(h, 1'b0) == 16'hFFFF);
        e.due  = cyc + LATENCY;
        sb.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            hdr_tvalid = 1'b0;
            hdr_tdata  = rand_hdr();
        end
    endtask

    // Result monitor: compare each beat against the scoreboard head, away from the edge.
    always @(negedge clk) begin
        if (!areset) begin
            if (res_tvalid) begin
                if (sb.size() == 0) begin
                    check("unexpected_beat", 64'(res_tvalid), 64'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("result_cycle", 64'(cyc), 64'(e.due));
                    check("result_tdata", 64'(res_tdata), {63'd0, e.pass});
                    check("result_side", {res_tlast, res_tkeep, res_tuser},
                          {1'b1, {OUT_BYTES{1'b1}}, {USER_W{1'b0}}});
                end
            end else if (sb.size() != 0 && sb[0].due <= cyc) begin
                exp_t e;
                e = sb.pop_front();
                check("missing_beat", 64'(res_tvalid), 64'd1);
            end
        end
    end

    initial begin : stimulus
        logic [159:0] ref_hdr;
        logic [159:0] h;
        int           waited;

        areset     = 1'b1;
        hdr_tdata  = '0;
        hdr_tvalid = 1'b0;
        hdr_tkeep  = '0;
        hdr_tlast  = 1'b0;
        hdr_tuser  = '0;
        res_tready = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset_tvalid", 64'(res_tvalid), 64'd0);
        check("reset_tdata", 64'(res_tdata), 64'd0);
        check("tready_high", 64'(hdr_tready), 64'd1);
        areset = 1'b0;
        idle(2);

        // Reference vector, then the same header with corrupted checksums
        ref_hdr = 160'h4500_0073_0000_4000_4011_B861_C0A8_0001_C0A8_00C7;
        beat(ref_hdr);
        idle(4);
        beat(with_cs(ref_hdr, 16'hB862));
        idle(4);
        beat(with_cs(ref_hdr, 16'h0000));
        idle(4);

        // Boundaries: all zero words, all-ones words, the two zeros of one's complement
        beat(160'd0);                                           // sum 0000 -> fail
        beat(with_cs(160'd0, 16'hFFFF));                        // sum FFFF -> pass
        beat({160{1'b1}});                                      // largest 20-bit total -> pass
        beat(with_cs({16'hFFFF, 144'd0}, 16'h0000));            // others sum FFFF, cs 0000 -> pass
        beat(with_cs({16'hFFFF, 144'd0}, 16'hFFFF));            // others sum FFFF, cs FFFF -> pass
        idle(5);

        // 100 good headers, then 100 bad headers, back to back; random idles after each block
        for (int i = 0; i < 100; i++) beat(good_hdr(rand_hdr()));
        idle(5);
        for (int i = 0; i < 100; i++) beat(bad_hdr(rand_hdr()));
        idle(5);

        // Random good/bad mix on consecutive cycles with occasional gaps
        for (int i = 0; i < 60; i++) begin
            h = rand_hdr();
            beat(($urandom_range(0, 1) == 1) ? good_hdr(h) : bad_hdr(h));
            if ($urandom_range(0, 7) == 0) idle(1);
        end
        idle(5);

        // Reset with two beats in flight: both must be dropped
        beat(good_hdr(rand_hdr()));
        beat(good_hdr(rand_hdr()));
        @(posedge clk);
        #3;
        hdr_tvalid = 1'b0;
        areset     = 1'b1;
        #1;
        check("areset_tvalid", 64'(res_tvalid), 64'd0);
        check("areset_tdata", 64'(res_tdata), 64'd0);
        sb.delete();
        repeat (2) @(posedge clk);
        #3;
        areset = 1'b0;
        idle(4);
        check("post_reset_idle", 64'(res_tvalid), 64'd0);

        // First beat after release is processed normally
        beat(ref_hdr);
        idle(1);

        // Drain the scoreboard within a bounded number of cycles
        waited = 0;
        while (sb.size() != 0 && waited < 50) begin
            @(posedge clk);
            waited++;
        end
        check("drain", 64'(sb.size()), 64'd0);
        idle(4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
